data_memory_ws: RTL and testbench

//  Parametrised word-addressed data memory with byte-enable writes, a configurable

---
 rtl/data_memory_ws.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_ws.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ws.sv
// data_memory_ws
//   Word-addressed data memory for the pipeline memory stage. It takes one
//   request at a time, inserts WAIT_CYCLES wait states, then performs the
//   read or byte-enabled write and returns a one-cycle response strobe.
//   Addresses with any bit set above the index field are rejected with an
//   error response, and the array is left untouched.
//
// Ports
//   clk           : single clock, all logic on the rising edge
//   rst           : synchronous active-high reset of the control state
//   in_req        : access request, taken only while out_ready is high
//   in_ctrl_write : 1 = write, 0 = read, sampled together with in_req
//   in_addr       : 32-bit word address
//   in_data       : write data
//   in_be         : byte enables, bit b covers in_data[8b+7:8b]
//   out_ready     : block is idle and will accept a request this cycle
//   out_valid     : one-cycle response strobe
//   out_err       : response is an out-of-range error (qualified by out_valid)
//   out_data      : read data, or the merged word after a write
module data_memory_ws #(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 16,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_req,
  input  logic                in_ctrl_write,
  input  logic [31:0]         in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_be,
  output logic                out_ready,
  output logic                out_valid,
  output logic                out_err,
  output logic [DATA_W-1:0]   out_data
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic [31:0]        req_addr;
  logic [DATA_W-1:0]  req_data;
  logic [BE_W-1:0]    req_be;
  logic               req_write;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  idx;
  logic               in_range;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  merged;
  logic               accept;

  // Power-up contents: an identity pattern so that every word reads back
  // its own index until it is written.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DATA_W'(i);
    end
  end

  assign out_ready = (state == ST_IDLE);
  assign accept    = in_req && (state == ST_IDLE);

  // Bits above the index field must all be zero; anything else would
  // silently alias onto a low word, so it is flagged as an error instead.
  assign in_range  = (req_addr[31:ADDR_W] == '0);
  assign idx       = req_addr[ADDR_W-1:0];
  assign rd_word   = mem[idx];

  // Overlay the enabled bytes of the write data onto the current word;
  // with no enables set this is simply the unchanged word.
  always_comb begin
    merged = rd_word;
    for (int b = 0; b < BE_W; b++) begin
      if (req_be[b]) begin
        merged[8*b +: 8] = req_data[8*b +: 8];
      end
    end
  end

  // State register and wait counter; reset drops any pending operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: with no wait states an accepted request goes straight
  // to ACCESS; otherwise the counter is loaded so WAIT lasts WAIT_CYCLES cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (in_req) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_ACCESS;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Request capture; the requester may change its inputs right after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_write <= 1'b0;
    end else if (accept) begin
      req_addr  <= in_addr;
      req_data  <= in_data;
      req_be    <= in_be;
      req_write <= in_ctrl_write;
    end
  end

  // Array write on the edge leaving ACCESS; reset on that same edge wins,
  // so an interrupted write never commits.
  always_ff @(posedge clk) begin
    if (!rst && (state == ST_ACCESS) && req_write && in_range) begin
      mem[idx] <= merged;
    end
  end

  // Response strobe; out_data holds its last value between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      if (state == ST_ACCESS) begin
        out_valid <= 1'b1;
        if (in_range) begin
          out_data <= req_write ? merged : rd_word;
        end else begin
          out_err  <= 1'b1;
          out_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// tb_data_memory_ws
//   Directed checks of data_memory_ws with DATA_W=32, ADDR_W=16,
//   WAIT_CYCLES=2 and the identity power-up pattern.
module tb_data_memory_ws;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_req;
  logic        in_ctrl_write;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_be;
  logic        out_ready;
  logic        out_valid;
  logic        out_err;
  logic [31:0] out_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_memory_ws #(
    .DATA_W      (32),
    .ADDR_W      (16),
    .WAIT_CYCLES (2),
    .INIT_FILE   ("")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_req        (in_req),
    .in_ctrl_write (in_ctrl_write),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .in_be         (in_be),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_err       (out_err),
    .out_data      (out_data)
  );

  // Single point of comparison for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request, drop it after the accepting edge, then wait a
  // bounded number of cycles for the response strobe.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be,
                               output logic [31:0] rdata, output logic err,
                               output int lat);
    @(negedge clk);
    checkOutput("ready_before_req", 32'(out_ready), 32'd1);
    in_req        = 1'b1;
    in_ctrl_write = wr;
    in_addr       = addr;
    in_data       = data;
    in_be         = be;
    @(posedge clk);
    #1;
    in_req = 1'b0;
    lat    = 0;
    rdata  = '0;
    err    = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat   = i;
        rdata = out_data;
        err   = out_err;
        break;
      end
    end
  endtask

  // One full access with latency, response and strobe-width checks.
  task automatic runAccess(input string tag, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic [31:0] exp_data,
                           input logic exp_err);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    applyStimulus(wr, addr, data, be, rdata, err, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
    checkOutput({tag, "_data"}, rdata, exp_data);
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    checkOutput({tag, "_strobe_one_cycle"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_err_cleared"}, 32'(out_err), 32'd0);
    checkOutput({tag, "_data_hold"}, out_data, exp_data);
  endtask

  initial begin
    int got;
    int nvalid;

    rst           = 1'b1;
    in_req        = 1'b0;
    in_ctrl_write = 1'b0;
    in_addr       = '0;
    in_data       = '0;
    in_be         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_ready", 32'(out_ready), 32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_err", 32'(out_err), 32'd0);
    checkOutput("rst_data", out_data, 32'h0);

    $display("[TB] basic read, full word write, partial write");
    runAccess("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h10, 1'b0);
    runAccess("wr20", 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
    runAccess("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    runAccess("wr30", 1'b1, 32'h30, 32'h12345678, 4'h3, 32'h00005678, 1'b0);
    runAccess("rd30", 1'b0, 32'h30, 32'h0, 4'h0, 32'h00005678, 1'b0);
    runAccess("wr50_be0", 1'b1, 32'h50, 32'hCAFEF00D, 4'h0, 32'h50, 1'b0);
    runAccess("wr84_mid", 1'b1, 32'h84, 32'hA1B2C3D4, 4'h6, 32'h00B2C384, 1'b0);

    $display("[TB] out of range");
    runAccess("wr_oor", 1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    runAccess("rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    runAccess("rd_oor_hi", 1'b0, 32'h8000_0005, 32'h0, 4'h0, 32'h0, 1'b1);
    runAccess("rd5", 1'b0, 32'h5, 32'h0, 4'h0, 32'h5, 1'b0);

    $display("[TB] back-to-back held request");
    @(negedge clk);
    in_req        = 1'b1;
    in_ctrl_write = 1'b0;
    in_addr       = 32'h1;
    @(posedge clk);
    got = 0;
    for (int c = 1; c <= 20 && got < 3; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checkOutput("held_data", out_data, 32'(got + 1));
        checkOutput("held_cycle", 32'(c), 32'(LAT * (got + 1)));
        checkOutput("held_ready", 32'(out_ready), 32'd1);
        got++;
        if (got < 3) begin
          in_addr = 32'(got + 1);
        end else begin
          in_req = 1'b0;
        end
      end
    end
    in_req = 1'b0;
    checkOutput("held_count", 32'(got), 32'd3);

    $display("[TB] reset during wait states");
    @(negedge clk);
    in_req        = 1'b1;
    in_ctrl_write = 1'b1;
    in_addr       = 32'h40;
    in_data       = 32'hAAAA5555;
    in_be         = 4'hF;
    @(posedge clk);
    #1;
    in_req = 1'b0;
    @(negedge clk);
    rst           = 1'b1;
    in_req        = 1'b1;
    in_ctrl_write = 1'b1;
    in_addr       = 32'h60;
    in_data       = 32'h0;
    in_be         = 4'hF;
    @(negedge clk);
    rst    = 1'b0;
    in_req = 1'b0;
    checkOutput("midrst_ready", 32'(out_ready), 32'd1);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_data", out_data, 32'h0);
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    checkOutput("midrst_no_valid", 32'(nvalid), 32'd0);
    runAccess("rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h40, 1'b0);
    runAccess("rd60", 1'b0, 32'h60, 32'h0, 4'h0, 32'h60, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
